tri_chan_gen: RTL

//  Parametrised triangle-class APU channel: wave-period timer, linear counter, step sequencer.

---
 rtl/tri_chan_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tri_chan_gen.sv
// Triangle-class APU channel: period timer, linear counter, step sequencer.
// Adds sawtooth, inverted and one-shot sequence modes plus a writable phase.
module tri_chan_gen #(
  parameter int FREQ_W = 11,
  parameter int LIN_W  = 7,
  parameter int STEP_W = 5,
  localparam int OUT_W = STEP_W - 1
) (
  input  logic             PHI1,
  input  logic             nRES,
  input  logic [7:0]       DB,
  input  logic             W_CTRL,
  input  logic             W_FLO,
  input  logic             W_FHI,
  input  logic             W_MODE,
  input  logic             W_SEQ,
  input  logic             LFO_STB,
  input  logic             NOTRI,
  input  logic             LOCK,
  output logic             TRI_LC,
  output logic [OUT_W-1:0] TRI_OUT,
  output logic             SEQ_WRAP
);

  logic [FREQ_W-1:0] period_q, period_d;
  logic [FREQ_W-1:0] cnt_q, cnt_d;
  logic [LIN_W-1:0]  rval_q, rval_d;
  logic [LIN_W-1:0]  lin_q, lin_d;
  logic              ctl_q, ctl_d;
  logic              rflag_q, rflag_d;
  logic              saw_q, saw_d;
  logic              inv_q, inv_d;
  logic              os_q, os_d;
  logic              done_q, done_d;
  logic [STEP_W-1:0] seq_q, seq_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              wrap_q, wrap_d;

  logic              fout;
  logic              tstep;
  logic [STEP_W-1:0] seq_inc;
  logic [OUT_W-1:0]  lvl;
  logic [OUT_W-1:0]  tri_raw;
  logic [OUT_W-1:0]  raw;

  assign fout    = (cnt_q == '0);
  assign tstep   = fout & (|lin_q) & ~NOTRI & ~LOCK & ~(os_q & done_q);
  assign seq_inc = seq_q + 1'b1;
  assign lvl     = seq_q[OUT_W-1:0];
  assign tri_raw = seq_q[STEP_W-1] ? lvl : ~lvl;
  assign raw     = saw_q ? seq_q[STEP_W-1:1] : tri_raw;

  // Next-state for timer, linear counter, registers and sequencer
  always_comb begin
    period_d = period_q;
    rval_d   = rval_q;
    ctl_d    = ctl_q;
    lin_d    = lin_q;
    rflag_d  = rflag_q;
    saw_d    = saw_q;
    inv_d    = inv_q;
    os_d     = os_q;
    done_d   = done_q;
    seq_d    = seq_q;
    cnt_d    = fout ? period_q : cnt_q - 1'b1;

    if (W_CTRL) begin
      ctl_d  = DB[7];
      rval_d = DB[LIN_W-1:0];
    end
    if (W_FLO)
      period_d[7:0] = DB;
    if (W_FHI)
      period_d[FREQ_W-1:8] = DB[FREQ_W-9:0];

    if (LFO_STB) begin
      if (rflag_q)
        lin_d = rval_q;
      else if (|lin_q)
        lin_d = lin_q - 1'b1;
    end

    if (W_FHI)
      rflag_d = 1'b1;
    else if (LFO_STB && !ctl_q)
      rflag_d = 1'b0;

    if (W_SEQ) begin
      seq_d  = DB[STEP_W-1:0];
      done_d = 1'b0;
    end else if (tstep) begin
      seq_d = seq_inc;
      if (os_q && (seq_inc == '1))
        done_d = 1'b1;
    end

    if (W_MODE) begin
      saw_d = DB[0];
      inv_d = DB[1];
      os_d  = DB[2];
      if (!DB[2])
        done_d = 1'b0;
    end

    wrap_d = tstep & ~W_SEQ & ~os_q & (seq_q == '1);
    out_d  = inv_q ? ~raw : raw;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge PHI1) begin
    if (!nRES) begin
      period_q <= '0;
      cnt_q    <= '0;
      rval_q   <= '0;
      lin_q    <= '0;
      ctl_q    <= 1'b0;
      rflag_q  <= 1'b0;
      saw_q    <= 1'b0;
      inv_q    <= 1'b0;
      os_q     <= 1'b0;
      done_q   <= 1'b0;
      seq_q    <= '0;
      out_q    <= '1;
      wrap_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      rval_q   <= rval_d;
      lin_q    <= lin_d;
      ctl_q    <= ctl_d;
      rflag_q  <= rflag_d;
      saw_q    <= saw_d;
      inv_q    <= inv_d;
      os_q     <= os_d;
      done_q   <= done_d;
      seq_q    <= seq_d;
      out_q    <= out_d;
      wrap_q   <= wrap_d;
    end
  end

  assign TRI_LC   = ~ctl_q;
  assign TRI_OUT  = out_q;
  assign SEQ_WRAP = wrap_q;

endmodule
